// File: rtl/guess_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : guess_pkg
//  Description : Shared types and constants for the guess_tracker datapath:
//                BCD digit types, secret-generator LFSR taps and seed,
//                default seconds per level and counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package guess_pkg;

    typedef logic [3:0]       bcd_digit_t;
    typedef bcd_digit_t [2:0] bcd3_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED      = 16'hACE1;
    localparam int          SEC_PER_LEVEL_DEF = 30;
    localparam int          TIMER_W           = 7;
    localparam int          CNT_W             = 3;

    // Fold a raw nibble into a decimal digit (10..15 -> 0..5)
    function automatic bcd_digit_t nibble_mod10(input logic [3:0] n);
        return (n > 4'd9) ? (n - 4'd10) : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/secret_gen.sv
`default_nettype none
// ============================================================================
//  Module      : secret_gen
//  Description : Free-running 16-bit Fibonacci LFSR that supplies candidate
//                secrets. Each nibble is folded mod 10 and digits at or above
//                max_digit are forced to zero.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                max_digit [1:0] - number of active digits (1..3)
//                secret          - candidate secret, three BCD digits
//  Revision    : 1.0 - initial release
// ============================================================================
module secret_gen
    import guess_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] max_digit,
    output bcd3_t      secret
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_digit
        assign secret[i] = (max_digit > 2'(i)) ? nibble_mod10(lfsr_q[4*i +: 4])
                                               : 4'd0;
    end

endmodule
`default_nettype wire

// File: rtl/guess_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : guess_tracker
//  Description : Per-game datapath ahead of the difficulty FSM. Holds the
//                secret, judges confirmed guesses, counts correct rounds and
//                wrong guesses, and runs the per-level countdown timer.
//  Ports       : clk, reset             - clock, sync active-high reset
//                confirm                - single-cycle confirm pulse
//                guess_bcd [11:0]       - player guess, [3:0] least significant
//                level [1:0]            - 0 idle, 1..3 playing
//                max_digit [1:0]        - active digit count
//                max_incorrect_guesses  - limit used for the locked flag
//                incorrect_guesses, round, timer, secret_bcd - state outputs
//                guess_ok, guess_bad    - one-cycle judge pulses
//                locked                 - guesses currently have no effect
//  Revision    : 1.0 - initial release
// ============================================================================
module guess_tracker
    import guess_pkg::*;
#(
    parameter int          CLK_HZ        = 50_000_000,
    parameter int          SEC_PER_LEVEL = SEC_PER_LEVEL_DEF,
    parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                confirm,
    input  logic [11:0]         guess_bcd,
    input  logic [1:0]          level,
    input  logic [1:0]          max_digit,
    input  logic [2:0]          max_incorrect_guesses,
    output logic [CNT_W-1:0]    incorrect_guesses,
    output logic [CNT_W-1:0]    round,
    output logic [TIMER_W-1:0]  timer,
    output logic [11:0]         secret_bcd,
    output logic                guess_ok,
    output logic                guess_bad,
    output logic                locked
);

    localparam int                 PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    logic [1:0]         level_q,   level_d;
    logic [CNT_W-1:0]   round_q,   round_d;
    logic [CNT_W-1:0]   inc_q,     inc_d;
    logic [TIMER_W-1:0] timer_q,   timer_d;
    logic [PRESC_W-1:0] presc_q,   presc_d;
    bcd3_t              secret_q,  secret_d;
    logic               ok_q,      ok_d;
    logic               bad_q,     bad_d;

    bcd3_t              gen_secret;
    logic               reload;
    logic               active;
    logic               accept;
    logic               match;
    logic [TIMER_W-1:0] reload_val;

    secret_gen #(
        .LFSR_SEED (LFSR_SEED)
    ) u_secret_gen (
        .clk       (clk),
        .reset     (reset),
        .max_digit (max_digit),
        .secret    (gen_secret)
    );

    always_comb begin
        reload     = (level != level_q) && (level != 2'd0);
        // Acceptance and ticking both look at pre-update values, so a confirm
        // in the same cycle the timer hits 0 is still judged.
        active     = (level != 2'd0) && (timer_q != '0);
        accept     = confirm && active && !reload;
        reload_val = TIMER_W'(SEC_PER_LEVEL) * {{(TIMER_W-2){1'b0}}, level};

        match = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (max_digit > 2'(i)) begin
                if ((guess_bcd[4*i +: 4] > 4'd9) ||
                    (guess_bcd[4*i +: 4] != secret_q[i])) begin
                    match = 1'b0;
                end
            end
        end

        level_d  = level;
        round_d  = round_q;
        inc_d    = inc_q;
        timer_d  = timer_q;
        presc_d  = presc_q;
        secret_d = secret_q;
        ok_d     = 1'b0;
        bad_d    = 1'b0;

        if (reload) begin
            // A confirm coinciding with a reload is dropped.
            round_d  = '0;
            inc_d    = '0;
            timer_d  = reload_val;
            presc_d  = '0;
            secret_d = gen_secret;
        end else begin
            if (active) begin
                if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    timer_d = timer_q - 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            if (accept) begin
                if (match) begin
                    ok_d     = 1'b1;
                    secret_d = gen_secret;
                    if (round_q != CNT_MAX) begin
                        round_d = round_q + 1'b1;
                    end
                end else begin
                    bad_d = 1'b1;
                    if (inc_q != CNT_MAX) begin
                        inc_d = inc_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q  <= 2'd0;
            round_q  <= '0;
            inc_q    <= '0;
            timer_q  <= '0;
            presc_q  <= '0;
            secret_q <= '0;
            ok_q     <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            level_q  <= level_d;
            round_q  <= round_d;
            inc_q    <= inc_d;
            timer_q  <= timer_d;
            presc_q  <= presc_d;
            secret_q <= secret_d;
            ok_q     <= ok_d;
            bad_q    <= bad_d;
        end
    end

    assign incorrect_guesses = inc_q;
    assign round             = round_q;
    assign timer             = timer_q;
    assign secret_bcd        = secret_q;
    assign guess_ok          = ok_q;
    assign guess_bad         = bad_q;
    assign locked            = (level == 2'd0) || (timer_q == '0) ||
                               (inc_q >= max_incorrect_guesses);

endmodule
`default_nettype wire

// File: doc/guess_tracker.md
Name: guess_tracker

Overview:
Per-game datapath that sits directly upstream of the difficulty state machine. It holds the secret number, judges each confirmed guess, and counts correct rounds and incorrect guesses. It also runs the per-level countdown timer. Its incorrect_guesses, round and timer outputs are the exact inputs the difficulty FSM evaluates on each confirm press; it consumes the FSM's level, max_digit and max_incorrect_guesses outputs.

Parameters:
CLK_HZ, 50_000_000, clock cycles per timer second (bench overrides to a small value, e.g. 10)
SEC_PER_LEVEL, 30, seconds loaded per difficulty level (reload = SEC_PER_LEVEL*level, max 90)
LFSR_SEED, 16'hACE1, non-zero reset seed of the secret generator

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
confirm  in  1  single-cycle confirm pulse (debounced/edge-detected upstream)
guess_bcd  in  12  three BCD digits entered by player, [3:0] = least significant
level  in  2  current difficulty from FSM: 0 = idle (win/gameover), 1..3 = playing
max_digit  in  2  number of active digits (1..3); higher digits are ignored
max_incorrect_guesses  in  3  limit from FSM, used only for the locked flag
incorrect_guesses  out  3  wrong guesses this level, saturates at 7
round  out  3  correct guesses this level, saturates at 7
timer  out  7  seconds remaining this level
secret_bcd  out  12  current secret, digits above max_digit are 0
guess_ok  out  1  one-cycle pulse: the previous confirm was judged correct
guess_bad  out  1  one-cycle pulse: the previous confirm was judged wrong
locked  out  1  high when level==0, timer==0 or incorrect_guesses>=max_incorrect_guesses

Behaviour:
- Reset: incorrect_guesses=0, round=0, timer=0, secret_bcd=0, guess_ok=0, guess_bad=0, prescaler=0, LFSR=LFSR_SEED, level_q=0.
- Reload: level_q registers level. A reload fires in the cycle where level != level_q and level != 0.
  - Next cycle: round=0, incorrect_guesses=0, timer=SEC_PER_LEVEL*level, prescaler=0.
  - secret_bcd takes a fresh value from the generator.
- When level becomes 0: counters and timer freeze at their current values; no reload.
- Secret generator: 16-bit Fibonacci LFSR with taps 16,14,13,11. It advances every clock, including during reset release.
  - Digit i = LFSR nibble i mapped mod 10 (values 10..15 have 10 subtracted).
  - Digits with index >= max_digit are forced to 0.
- Timer: the prescaler counts 0..CLK_HZ-1 while level!=0 and timer>0. On wrap, timer decrements by 1. It never goes below 0.
- Judging: a confirm is accepted only when level!=0 and timer>0. Judging has a 1-cycle latency, so outputs update on the cycle after the confirm.
  - Compare only the active digits of guess_bcd against secret_bcd.
  - Any active digit >9 counts as wrong.
  - Equal: round+1 (saturating), guess_ok pulse, new secret loaded in the same cycle.
  - Not equal: incorrect_guesses+1 (saturating), guess_bad pulse.
- Confirm while locked by timer==0 or level==0: no count change and no pulse.
  - Guesses past max_incorrect_guesses are still counted; the FSM decides game over.
- Simultaneous events:
  - Reload and confirm in the same cycle: reload wins and the confirm is dropped.
  - Confirm and timer wrap in the same cycle: both take effect.
  - Confirm while timer==1 and the wrap occurs in that same cycle: the confirm is judged, since acceptance is evaluated on pre-update values.
- Reset mid-level: immediate return to reset values. The next non-zero level after reset triggers a reload.

Decomposition:
- Package guess_pkg holds:
  - typedef bcd_digit_t (logic [3:0]), typedef bcd3_t (bcd_digit_t [2:0])
  - constants LFSR_TAPS, DEFAULT_SEED, SEC_PER_LEVEL_DEF, TIMER_W=7, CNT_W=3
- One sub-module, secret_gen: LFSR, mod-10 mapping and max_digit masking. Output is bcd3_t.
- Prescaler, counters and compare logic stay in guess_tracker.

Test Plan:
1. reset high 3 cycles, then level 0 -> 1 with max_digit=1, CLK_HZ=10 -> next cycle timer=30, round=0, incorrect=0; after 10 cycles timer=29.
2. Level 1: confirm with guess_bcd equal to secret_bcd -> 1 cycle later guess_ok=1 for 1 cycle, round=1, secret changes; digit1 and digit2 of secret stay 0.
3. Level 2 (max_digit=2, timer=60): confirm guess 12'h0A5 (invalid digit) -> guess_bad pulse, incorrect=1; 8 further wrong confirms -> incorrect saturates at 7; locked=1 once incorrect>=max_incorrect_guesses (4).
4. Run level 1 until timer reaches 0 -> timer holds at 0, locked=1; confirm produces no pulse and no count change.
5. Assert confirm in the same cycle level changes 1 -> 2 -> no judge pulse; round=0, incorrect=0, timer=60.
6. Mid-level (round=3, timer=17): pulse reset -> all outputs 0, LFSR=16'hACE1; re-assert level=1 -> reload to timer=30.
